// File: rtl/jkff_drive.sv
// Command-level driver for a bank of jkff primitives on a shared cp pin.
// Expands LOAD/TOGGLE/PRESET/CLEAR into timed pin sequences and returns sampled q.
module jkff_drive #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SETUP = 1,
    parameter int unsigned HIGH  = 2,
    parameter int unsigned LOW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cp,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q_in,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_q,
    output logic             rsp_err
);

    localparam int unsigned MAXSH = (SETUP > HIGH) ? SETUP : HIGH;
    localparam int unsigned MAXC  = (MAXSH > LOW) ? MAXSH : LOW;
    localparam int unsigned CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] C_SETUP = CW'(SETUP - 1);
    localparam logic [CW-1:0] C_HIGH  = CW'(HIGH - 1);
    localparam logic [CW-1:0] C_LOW   = CW'(LOW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_PULSE,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    state_t          w_state_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic            w_err_nx;
    logic            w_cp_nx;
    logic [WIDTH-1:0] w_j_nx;
    logic [WIDTH-1:0] w_k_nx;
    logic [WIDTH-1:0] w_s_nx;
    logic [WIDTH-1:0] w_r_nx;
    logic            w_rsp_valid_nx;
    logic [WIDTH-1:0] w_rsp_q_nx;
    logic            w_rsp_err_nx;

    assign cmd_ready = (r_state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            cp        <= 1'b0;
            j         <= '0;
            k         <= '0;
            s         <= '0;
            r         <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_err     <= w_err_nx;
            cp        <= w_cp_nx;
            j         <= w_j_nx;
            k         <= w_k_nx;
            s         <= w_s_nx;
            r         <= w_r_nx;
            rsp_valid <= w_rsp_valid_nx;
            rsp_q     <= w_rsp_q_nx;
            rsp_err   <= w_rsp_err_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_err_nx       = r_err;
        w_cp_nx        = cp;
        w_j_nx         = j;
        w_k_nx         = k;
        w_s_nx         = s;
        w_r_nx         = r;
        w_rsp_valid_nx = 1'b0;
        w_rsp_q_nx     = rsp_q;
        w_rsp_err_nx   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        3'd1: begin
                            w_j_nx     = cmd_data & cmd_mask;
                            w_k_nx     = ~cmd_data & cmd_mask;
                            w_cnt_nx   = C_SETUP;
                            w_state_nx = S_SETUP;
                        end
                        3'd2: begin
                            w_j_nx     = cmd_mask;
                            w_k_nx     = cmd_mask;
                            w_cnt_nx   = C_SETUP;
                            w_state_nx = S_SETUP;
                        end
                        3'd3: begin
                            w_s_nx     = cmd_mask;
                            w_r_nx     = '0;
                            w_cnt_nx   = C_HIGH;
                            w_state_nx = S_PULSE;
                        end
                        3'd4: begin
                            w_s_nx     = '0;
                            w_r_nx     = cmd_mask;
                            w_cnt_nx   = C_HIGH;
                            w_state_nx = S_PULSE;
                        end
                        default: begin
                            // NOP/reserved reuse RELEASE with a zero count to answer one cycle later
                            w_err_nx   = (cmd_op > 3'd4);
                            w_cnt_nx   = '0;
                            w_state_nx = S_RELEASE;
                        end
                    endcase
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_cp_nx    = 1'b1;
                    w_cnt_nx   = C_HIGH;
                    w_state_nx = S_HIGH;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_HIGH: begin
                if (r_cnt == '0) begin
                    w_cp_nx    = 1'b0;
                    w_cnt_nx   = C_LOW;
                    w_state_nx = S_LOW;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_LOW: begin
                if (r_cnt == '0) begin
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_q_nx     = q_in;
                    w_j_nx         = '0;
                    w_k_nx         = '0;
                    w_state_nx     = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_s_nx     = '0;
                    w_r_nx     = '0;
                    w_cnt_nx   = C_LOW;
                    w_state_nx = S_RELEASE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_RELEASE: begin
                if (r_cnt == '0) begin
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_q_nx     = q_in;
                    w_rsp_err_nx   = r_err;
                    w_err_nx       = 1'b0;
                    w_state_nx     = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_err_nx   = 1'b0;
                w_cp_nx    = 1'b0;
                w_j_nx     = '0;
                w_k_nx     = '0;
                w_s_nx     = '0;
                w_r_nx     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_jkff_drive.sv
// Bench for jkff_drive: behavioural jkff bank as the plant, command-level flop
// model feeding a response scoreboard, plus a per-cycle pin timeline check.
module tb_jkff_drive;

    localparam int W  = 4;
    localparam int ST = 1;
    localparam int HI = 2;
    localparam int LO = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_mask;
    logic [W-1:0] cmd_data;
    logic         cp;
    logic [W-1:0] j, k, s, r;
    logic [W-1:0] q_in;
    logic         rsp_valid;
    logic [W-1:0] rsp_q;
    logic         rsp_err;

    always #5 clk = ~clk;

    jkff_drive #(.WIDTH(W), .SETUP(ST), .HIGH(HI), .LOW(LO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
        .cp(cp), .j(j), .k(k), .s(s), .r(r), .q_in(q_in),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err)
    );

    // Behavioural jkff bank: rising-cp JK update, async set/reset.
    logic [W-1:0] bank_q = 4'b0110;
    logic         cp_d   = 1'b0;
    always @(cp or s or r) begin
        if (cp && !cp_d) begin
            for (int i = 0; i < W; i++) begin
                if (j[i] && k[i])  bank_q[i] = ~bank_q[i];
                else if (j[i])     bank_q[i] = 1'b1;
                else if (k[i])     bank_q[i] = 1'b0;
            end
        end
        cp_d   = cp;
        bank_q = (bank_q | s) & ~r;
    end
    assign q_in = bank_q;

    typedef struct {
        logic [W-1:0] q;
        logic         err;
        int           due;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_q = 4'b0110;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           chk_en = 1'b0;
    int           busy_until = 0;
    bit           d_active = 1'b0;
    logic [2:0]   d_op = 3'd0;
    logic [W-1:0] d_mask = '0;
    logic [W-1:0] d_data = '0;
    int           d_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic issue(input logic [2:0] op, input logic [W-1:0] m, input logic [W-1:0] d);
        int   lat;
        bit   got;
        exp_t e;
        got       = 1'b0;
        cmd_op    = op;
        cmd_mask  = m;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout op=%0d cmd_ready=%b want 1", op, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        case (op)
            3'd1: begin lat = ST + HI + LO; model_q = (model_q & ~m) | (d & m); end
            3'd2: begin lat = ST + HI + LO; model_q = model_q ^ m; end
            3'd3: begin lat = HI + LO;      model_q = model_q | m; end
            3'd4: begin lat = HI + LO;      model_q = model_q & ~m; end
            default: lat = 1;
        endcase
        e.q   = model_q;
        e.err = (op > 3'd4);
        e.due = cyc + lat;
        sb.push_back(e);
        d_op       = op;
        d_mask     = m;
        d_data     = d;
        d_start    = cyc;
        d_active   = 1'b1;
        busy_until = cyc + lat;
        cmd_valid  = 1'b0;
        cmd_op     = 3'($urandom);
        cmd_mask   = W'($urandom);
        cmd_data   = W'($urandom);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pin timeline derived from command start, ready, and scoreboard pops.
    always @(negedge clk) begin
        if (chk_en) begin
            logic         e_cp;
            logic [W-1:0] e_j, e_k, e_s, e_r;
            logic         e_rdy;
            int           t;
            exp_t         e;
            e_cp = 1'b0; e_j = '0; e_k = '0; e_s = '0; e_r = '0;
            t = cyc - d_start;
            if (d_active) begin
                case (d_op)
                    3'd1, 3'd2: begin
                        if (t >= 0 && t < ST + HI + LO) begin
                            e_j = (d_op == 3'd1) ? (d_data & d_mask) : d_mask;
                            e_k = (d_op == 3'd1) ? (~d_data & d_mask) : d_mask;
                        end
                        e_cp = (t >= ST) && (t < ST + HI);
                    end
                    3'd3: if (t >= 0 && t < HI) e_s = d_mask;
                    3'd4: if (t >= 0 && t < HI) e_r = d_mask;
                    default: ;
                endcase
            end
            total++;
            if ({cp, j, k, s, r} !== {e_cp, e_j, e_k, e_s, e_r}) begin
                bad++;
                $display("FAIL pins cyc=%0d got cp=%b j=%b k=%b s=%b r=%b want cp=%b j=%b k=%b s=%b r=%b",
                         cyc, cp, j, k, s, r, e_cp, e_j, e_k, e_s, e_r);
            end
            e_rdy = !rst && (cyc >= busy_until);
            total++;
            if (cmd_ready !== e_rdy) begin
                bad++;
                $display("FAIL ready cyc=%0d got %b want %b", cyc, cmd_ready, e_rdy);
            end
            if (rsp_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected cyc=%0d got rsp_valid=1 want 0", cyc);
                end else begin
                    e = sb.pop_front();
                    if (rsp_q !== e.q || rsp_err !== e.err || cyc != e.due) begin
                        bad++;
                        $display("FAIL rsp cyc=%0d got q=%b err=%b want q=%b err=%b at cyc=%0d",
                                 cyc, rsp_q, rsp_err, e.q, e.err, e.due);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_mask  = '0;
        cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_q !== '0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp got v=%b q=%b err=%b want 0 0000 0", rsp_valid, rsp_q, rsp_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        issue(3'd4, 4'b1111, 4'b0000);          // CLEAR
        idle(6);
        issue(3'd1, 4'b1111, 4'b1010);          // LOAD 1010
        idle(7);
        issue(3'd2, 4'b0011, 4'b0000);          // TOGGLE -> 1001
        issue(3'd1, 4'b0100, 4'b0000);          // LOAD bit 2 to 0
        idle(7);
        issue(3'd3, 4'b1111, 4'b0000);          // PRESET then NOP back-to-back
        issue(3'd0, 4'b0000, 4'b0000);
        idle(3);
        issue(3'd6, 4'b1111, 4'b1111);          // reserved
        idle(3);
        issue(3'd1, 4'b0000, 4'b1111);          // mask=0 still pulses cp
        idle(7);

        issue(3'd1, 4'b1111, 4'b0101);          // reset during HIGH
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        d_active   = 1'b0;
        busy_until = 0;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending responses want 0", sb.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
